// File: rtl/brm_store.sv
// brm_store -- backup-RAM storage stage behind the cartridge backup-RAM mapper.
//
// Holds the 2 KB backup RAM and returns read data to the mapper. It records
// which 256-byte pages the game has modified. After writes have been quiet for
// IDLE_CYC clocks it raises a save request to the MCU. The MCU copies the RAM
// out through a low-priority read port, then acknowledges.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   brm_ce          backup-RAM select from the mapper
//   brm_oe, brm_we  CPU read / write strobes (levels, may span many cycles)
//   brm_addr        CPU byte address (11 bits)
//   brm_dati        CPU write data
//   brm_dato        CPU read data, one clock after address/strobe
//   mcu_addr        MCU read address
//   mcu_rd          one-cycle MCU read request
//   mcu_dato        MCU read data, valid while mcu_rdy is high
//   mcu_rdy         one-cycle pulse marking mcu_dato valid
//   save_req        level: unsaved changes present and writes have gone quiet
//   save_ack        one-cycle pulse from the MCU, copy finished (ignored unless
//                   save_req is high)
//   dirty_map       per-page dirty bits, bit n covers bytes n*256 .. n*256+255
//
// Handshakes: mcu_rd is a request pulse, with no ready. A request is held in a
// single pending slot until the RAM port is free. A newer request replaces an
// older one that has not yet been served, so only one mcu_rdy results.
// save_req stays high until save_ack is seen.
module brm_store #(
    parameter logic [23:0] IDLE_CYC  = 24'd5_000_000,
    parameter logic [7:0]  INIT_FILL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        brm_ce,
    input  logic        brm_oe,
    input  logic        brm_we,
    input  logic [10:0] brm_addr,
    input  logic [7:0]  brm_dati,
    output logic [7:0]  brm_dato,
    input  logic [10:0] mcu_addr,
    input  logic        mcu_rd,
    output logic [7:0]  mcu_dato,
    output logic        mcu_rdy,
    output logic        save_req,
    input  logic        save_ack,
    output logic [7:0]  dirty_map
);

    typedef enum logic [1:0] {
        S_CLEAN = 2'd0,
        S_COUNT = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    // Memory contents survive reset; only power-up sets them to INIT_FILL.
    logic [7:0] mem [0:2047] = '{default: INIT_FILL};

    logic        cpu_wr;
    logic        cpu_rd;
    logic        commit;
    logic        mcu_svc;
    logic        wr_active;
    logic        wr_block;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        pend;
    logic [10:0] pend_addr;
    logic [7:0]  commit_bit;

    state_t      state, state_nx;
    logic [23:0] cnt, cnt_nx;
    logic [7:0]  dirty_nx;
    logic [7:0]  redirty, redirty_nx;

    assign cpu_wr = brm_ce & brm_we;
    // A write commits once, on the first cycle after the strobe falls.
    assign commit = wr_active & ~cpu_wr & ~rst;
    // A commit owns the single RAM port. A CPU read that collides with it is
    // served on the next cycle, because the strobe is a level.
    assign cpu_rd = brm_ce & brm_oe & ~commit;
    // The MCU only gets the port when the CPU side is idle. A request arriving
    // this cycle replaces the slot, so the slot is not served in the same
    // cycle.
    assign mcu_svc = pend & ~brm_ce & ~commit & ~mcu_rd;
    assign commit_bit = commit ? (8'h01 << wr_addr[10:8]) : 8'h00;
    assign save_req = (state == S_REQ);

    // Write capture. wr_block stays set after reset until the write strobe has
    // been seen low. This stops a write that spans reset from committing later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_block  <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_active <= cpu_wr & ~wr_block;
            if (!cpu_wr) begin
                wr_block <= 1'b0;
            end
            if (cpu_wr) begin
                wr_addr <= brm_addr;
                wr_data <= brm_dati;
            end
        end
    end

    // Single-port RAM with registered read data for each requester.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_addr] <= wr_data;
        end
        if (rst) begin
            brm_dato <= '0;
            mcu_dato <= '0;
            mcu_rdy  <= 1'b0;
        end else begin
            mcu_rdy <= mcu_svc;
            if (cpu_rd) begin
                brm_dato <= mem[brm_addr];
            end else if (mcu_svc) begin
                mcu_dato <= mem[pend_addr];
            end
        end
    end

    // Pending MCU request slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (mcu_rd) begin
            pend      <= 1'b1;
            pend_addr <= mcu_addr;
        end else if (mcu_svc) begin
            pend <= 1'b0;
        end
    end

    // Save FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAN;
            cnt       <= '0;
            dirty_map <= '0;
            redirty   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dirty_map <= dirty_nx;
            redirty   <= redirty_nx;
        end
    end

    // Save FSM: next state.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        dirty_nx   = dirty_map | commit_bit;
        redirty_nx = redirty;
        case (state)
            S_CLEAN: begin
                cnt_nx = '0;
                if (commit) begin
                    state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                // A commit restarts the quiet period, even on the terminal
                // count.
                if (commit) begin
                    cnt_nx = '0;
                end else if (cnt == IDLE_CYC - 24'd1) begin
                    state_nx   = S_REQ;
                    cnt_nx     = '0;
                    redirty_nx = '0;
                end else if (cnt != 24'hFF_FFFF) begin
                    cnt_nx = cnt + 24'd1;
                end
            end
            S_REQ: begin
                cnt_nx     = '0;
                redirty_nx = redirty | commit_bit;
                // On save_ack, keep only the pages written after the MCU
                // started copying, including a commit on this same cycle.
                if (save_ack) begin
                    dirty_nx = redirty | commit_bit;
                    state_nx = ((redirty | commit_bit) == 8'h00) ? S_CLEAN : S_COUNT;
                end
            end
            default: begin
                state_nx = S_CLEAN;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_brm_store.sv
// tb_brm_store -- self-checking bench for brm_store.
// Inputs are driven on the falling edge. A reference model updates on the
// rising edge from what the driver tasks declare: which commits happen, the
// RAM contents, dirty pages and the quiet-time save request. Outputs are
// compared on the next falling edge.
module tb_brm_store;

    localparam logic [23:0] IDLE = 24'd16;
    localparam logic [7:0]  FILL = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        brm_ce, brm_oe, brm_we;
    logic [10:0] brm_addr;
    logic [7:0]  brm_dati;
    logic [7:0]  brm_dato;
    logic [10:0] mcu_addr;
    logic        mcu_rd;
    logic [7:0]  mcu_dato;
    logic        mcu_rdy;
    logic        save_req;
    logic        save_ack;
    logic [7:0]  dirty_map;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    logic [7:0]  ref_mem [0:2047];
    logic [7:0]  m_dirty   = 8'h00;
    logic [7:0]  m_redirty = 8'h00;
    logic [7:0]  m_dato    = 8'h00;
    logic [7:0]  m_cbit;
    bit          m_req     = 1'b0;
    int          m_quiet   = 0;
    bit          m_commit  = 1'b0;
    logic [10:0] m_caddr   = '0;
    logic [7:0]  m_cdata   = '0;

    brm_store #(.IDLE_CYC(IDLE), .INIT_FILL(FILL)) dut (
        .clk       (clk),
        .rst       (rst),
        .brm_ce    (brm_ce),
        .brm_oe    (brm_oe),
        .brm_we    (brm_we),
        .brm_addr  (brm_addr),
        .brm_dati  (brm_dati),
        .brm_dato  (brm_dato),
        .mcu_addr  (mcu_addr),
        .mcu_rd    (mcu_rd),
        .mcu_dato  (mcu_dato),
        .mcu_rdy   (mcu_rdy),
        .save_req  (save_req),
        .save_ack  (save_ack),
        .dirty_map (dirty_map)
    );

    // Clock / reset block.
    always #5 clk = ~clk;

    // Model: the save request rises once a dirty RAM has seen IDLE clocks
    // without a commit. save_ack during a request keeps only the pages
    // written during the request.
    always @(posedge clk) begin
        if (rst) begin
            m_dirty   = 8'h00;
            m_redirty = 8'h00;
            m_req     = 1'b0;
            m_quiet   = 0;
            m_dato    = 8'h00;
        end else begin
            m_cbit = m_commit ? (8'h01 << m_caddr[10:8]) : 8'h00;
            if (brm_ce && brm_oe && !m_commit) m_dato = ref_mem[brm_addr];
            if (m_commit) ref_mem[m_caddr] = m_cdata;
            if (m_req) begin
                if (save_ack) begin
                    m_dirty = m_redirty | m_cbit;
                    m_req   = 1'b0;
                    m_quiet = 0;
                end else begin
                    m_dirty   = m_dirty | m_cbit;
                    m_redirty = m_redirty | m_cbit;
                end
            end else begin
                m_dirty = m_dirty | m_cbit;
                if (m_commit || m_dirty == 8'h00) m_quiet = 0;
                else m_quiet = m_quiet + 1;
                if (m_quiet >= int'(IDLE)) begin
                    m_req     = 1'b1;
                    m_redirty = 8'h00;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare the continuously tracked outputs.
    task automatic step();
        @(negedge clk);
        check("save_req", {31'd0, save_req}, {31'd0, m_req});
        check("dirty_map", {24'd0, dirty_map}, {24'd0, m_dirty});
        check("brm_dato_hold", {24'd0, brm_dato}, {24'd0, m_dato});
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Hold the write strobe for `hold` cycles. Only the last cycle carries the
    // real address/data; earlier cycles carry junk that must not be committed.
    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d, input int hold, input bit ack);
        brm_ce = 1'b1;
        brm_we = 1'b1;
        brm_oe = 1'b0;
        for (int i = 0; i < hold; i++) begin
            brm_addr = (i == hold - 1) ? a : 11'($urandom_range(0, 2047));
            brm_dati = (i == hold - 1) ? d : 8'($urandom_range(0, 255));
            step();
        end
        brm_ce   = 1'b0;
        brm_we   = 1'b0;
        m_commit = 1'b1;
        m_caddr  = a;
        m_cdata  = d;
        save_ack = ack;
        step();
        m_commit = 1'b0;
        save_ack = 1'b0;
    endtask

    task automatic cpu_read(input logic [10:0] a);
        brm_ce   = 1'b1;
        brm_oe   = 1'b1;
        brm_addr = a;
        step();
        brm_ce = 1'b0;
        brm_oe = 1'b0;
        check("cpu_read", {24'd0, brm_dato}, {24'd0, ref_mem[a]});
    endtask

    task automatic do_ack();
        save_ack = 1'b1;
        step();
        save_ack = 1'b0;
    endtask

    task automatic wait_req(output int el);
        el = 0;
        while (!save_req && el < 200) begin
            step();
            el++;
        end
        check("save_req_timeout", {31'd0, save_req}, 32'd1);
    endtask

    // MCU read while the CPU holds brm_ce (reading address ca) for `hold` cycles.
    task automatic mcu_read(input logic [10:0] a, input int hold, input logic [10:0] ca);
        int lat;
        mcu_rd   = 1'b1;
        mcu_addr = a;
        if (hold > 0) begin
            brm_ce   = 1'b1;
            brm_oe   = 1'b1;
            brm_addr = ca;
        end
        step();
        mcu_rd = 1'b0;
        for (int i = 1; i < hold; i++) begin
            check("mcu_rdy_while_ce", {31'd0, mcu_rdy}, 32'd0);
            step();
        end
        check("mcu_rdy_while_ce", {31'd0, mcu_rdy}, 32'd0);
        if (hold > 0) check("cpu_read_during_mcu", {24'd0, brm_dato}, {24'd0, ref_mem[ca]});
        brm_ce = 1'b0;
        brm_oe = 1'b0;
        lat = 0;
        while (!mcu_rdy && lat < 6) begin
            step();
            lat++;
        end
        check("mcu_rdy_timeout", {31'd0, mcu_rdy}, 32'd1);
        check("mcu_latency", lat, 32'd1);
        check("mcu_dato", {24'd0, mcu_dato}, {24'd0, ref_mem[a]});
        step();
        check("mcu_rdy_pulse", {31'd0, mcu_rdy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int el;
        int rdy_count;
        for (int i = 0; i < 2048; i++) ref_mem[i] = FILL;
        rst = 1'b1; brm_ce = 1'b0; brm_oe = 1'b0; brm_we = 1'b0;
        brm_addr = '0; brm_dati = '0; mcu_addr = '0; mcu_rd = 1'b0; save_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_brm_dato", {24'd0, brm_dato}, 32'd0);
        check("rst_mcu_dato", {24'd0, mcu_dato}, 32'd0);
        check("rst_mcu_rdy", {31'd0, mcu_rdy}, 32'd0);
        check("rst_save_req", {31'd0, save_req}, 32'd0);
        check("rst_dirty", {24'd0, dirty_map}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Power-up fill, then a single long write and read-back.
        cpu_read(11'h400);
        cpu_write(11'h123, 8'h5A, 6, 1'b0);
        check("dirty_after_write", {24'd0, dirty_map}, 32'h02);
        cpu_read(11'h123);

        // Quiet period, then acknowledge back to clean.
        wait_req(el);
        check("req_latency_single", el, 32'd15);
        do_ack();
        check("ack_clears_req", {31'd0, save_req}, 32'd0);
        check("ack_clears_dirty", {24'd0, dirty_map}, 32'd0);

        // A second write restarts the quiet period.
        cpu_write(11'h010, 8'h11, 2, 1'b0);
        idle(7);
        cpu_write(11'h7A0, 8'h22, 2, 1'b0);
        wait_req(el);
        check("req_latency_restart", el, 32'd16);
        check("dirty_two_pages", {24'd0, dirty_map}, 32'h81);
        do_ack();

        // Write during a request: the page survives save_ack.
        cpu_write(11'h0FF, 8'h33, 1, 1'b0);
        wait_req(el);
        check("dirty_page0", {24'd0, dirty_map}, 32'h01);
        cpu_write(11'h345, 8'h77, 1, 1'b0);
        check("dirty_in_req", {24'd0, dirty_map}, 32'h09);
        do_ack();
        check("redirty_after_ack", {24'd0, dirty_map}, 32'h08);
        check("req_drops", {31'd0, save_req}, 32'd0);
        wait_req(el);
        check("req_rerise", el, 32'd16);

        // Commit on the same cycle as save_ack.
        cpu_write(11'h5C0, 8'h44, 1, 1'b1);
        check("commit_with_ack", {24'd0, dirty_map}, 32'h20);
        check("commit_with_ack_req", {31'd0, save_req}, 32'd0);
        wait_req(el);
        do_ack();

        // MCU read starved by a held brm_ce.
        cpu_write(11'h7FF, 8'hC3, 1, 1'b0);
        mcu_read(11'h7FF, 20, 11'h123);
        mcu_read(11'h123, 0, 11'h000);

        // A second request replaces the pending one; only one mcu_rdy results.
        mcu_rd = 1'b1; mcu_addr = 11'h0FF; brm_ce = 1'b1;
        step();
        mcu_addr = 11'h345;
        step();
        mcu_rd = 1'b0;
        step();
        brm_ce = 1'b0;
        rdy_count = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mcu_rdy) begin
                rdy_count++;
                check("mcu_overwrite_data", {24'd0, mcu_dato}, {24'd0, ref_mem[11'h345]});
            end
        end
        check("mcu_overwrite_count", rdy_count, 32'd1);

        // Reset in the middle of a held write.
        brm_ce = 1'b1; brm_we = 1'b1; brm_addr = 11'h123; brm_dati = 8'hEE;
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        brm_ce = 1'b0; brm_we = 1'b0;
        idle(3);
        check("rst_write_dirty", {24'd0, dirty_map}, 32'd0);
        check("rst_write_req", {31'd0, save_req}, 32'd0);
        cpu_read(11'h123);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: cpu_write(11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)),
                             int'($urandom_range(1, 4)), m_req && ($urandom_range(0, 1) == 1));
                1: cpu_read(11'($urandom_range(0, 2047)));
                2: mcu_read(11'($urandom_range(0, 2047)), int'($urandom_range(0, 3)),
                            11'($urandom_range(0, 2047)));
                default: idle(int'($urandom_range(0, 20)));
            endcase
            if (m_req && $urandom_range(0, 2) == 0) do_ack();
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
